// File: rtl/alu_pkg.sv
// Shared opcode constants, compare encodings, FSM state and shift-kind enums
// for the alu_exec execution unit.
package alu_pkg;

  localparam logic [6:0] OP_ADD   = 7'h00;
  localparam logic [6:0] OP_SUB   = 7'h01;
  localparam logic [6:0] OP_LUI   = 7'h20;
  localparam logic [6:0] OP_SCOMP = 7'h24;
  localparam logic [6:0] OP_SLL   = 7'h28;
  localparam logic [6:0] OP_SRL   = 7'h2C;
  localparam logic [6:0] OP_SRA   = 7'h30;
  localparam logic [6:0] OP_AND   = 7'h34;
  localparam logic [6:0] OP_OR    = 7'h38;
  localparam logic [6:0] OP_XOR   = 7'h3C;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_LT   = 2'b10;
  localparam logic [1:0] BR_LTU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_kind_t;

  // One-bit shift step; SRA replicates bit 31, which never changes while shifting.
  function automatic logic [31:0] shift_one(input logic [31:0] v, input shift_kind_t k);
    case (k)
      SH_SLL:  shift_one = {v[30:0], 1'b0};
      SH_SRL:  shift_one = {1'b0, v[31:1]};
      SH_SRA:  shift_one = {v[31], v[31:1]};
      default: shift_one = v;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Operation/result handshake bundle between a producer (master) and alu_exec (slave).
interface alu_exec_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  alu_ctrl;
  logic        neg;
  logic [1:0]  br_ctrl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cond;
  logic        illegal;

  modport slave (
    input  in_valid, alu_ctrl, neg, br_ctrl, src_a, src_b, out_ready,
    output in_ready, out_valid, result, cond, illegal
  );

  modport master (
    output in_valid, alu_ctrl, neg, br_ctrl, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, cond, illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational opcode decode and single-cycle datapath (arith, logic, compare).
module alu_decoder
  import alu_pkg::*;
(
  input  logic [6:0]  alu_ctrl_i,
  input  logic        neg_i,
  input  logic [1:0]  br_ctrl_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  output logic [31:0] result_o,
  output logic        cond_o,
  output logic        illegal_o,
  output logic        is_shift_o,
  output shift_kind_t shift_kind_o
);

  logic raw_s;

  // Raw compare outcome selected by br_ctrl.
  always_comb begin
    raw_s = 1'b0;
    case (br_ctrl_i)
      BR_EQ:   raw_s = (src_a_i == src_b_i);
      BR_LT:   raw_s = ($signed(src_a_i) < $signed(src_b_i));
      BR_LTU:  raw_s = (src_a_i < src_b_i);
      default: raw_s = 1'b0;
    endcase
  end

  // Opcode decode; shift ops only flag themselves, the shifter produces their value.
  always_comb begin
    result_o     = 32'd0;
    cond_o       = 1'b0;
    illegal_o    = 1'b0;
    is_shift_o   = 1'b0;
    shift_kind_o = SH_SLL;
    case (alu_ctrl_i)
      OP_ADD:   result_o = src_a_i + src_b_i;
      OP_SUB:   result_o = src_a_i - src_b_i;
      OP_LUI:   result_o = src_b_i;
      OP_AND:   result_o = src_a_i & src_b_i;
      OP_OR:    result_o = src_a_i | src_b_i;
      OP_XOR:   result_o = src_a_i ^ src_b_i;
      OP_SCOMP: begin
        cond_o   = raw_s ^ neg_i;
        result_o = {31'd0, raw_s ^ neg_i};
      end
      OP_SLL: begin
        is_shift_o   = 1'b1;
        shift_kind_o = SH_SLL;
      end
      OP_SRL: begin
        is_shift_o   = 1'b1;
        shift_kind_o = SH_SRL;
      end
      OP_SRA: begin
        is_shift_o   = 1'b1;
        shift_kind_o = SH_SRA;
      end
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_shifter.sv
// Shift datapath: iterative one-bit-per-cycle by default, or a single-cycle
// barrel shifter when ALU_EXEC_BARREL_SHIFT_EN is defined.
module alu_shifter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
  input  shift_kind_t kind_i,
  input  logic [31:0] a_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] imm_o,
  output logic        imm_done_o,
  output logic [31:0] step_val_o,
  output logic [31:0] val_o,
  output logic        last_o
);

`ifdef ALU_EXEC_BARREL_SHIFT_EN
  logic unused_s;

  // Full shift in one cycle; every shift completes on acceptance.
  always_comb begin
    case (kind_i)
      SH_SLL:  imm_o = a_i << shamt_i;
      SH_SRL:  imm_o = a_i >> shamt_i;
      SH_SRA:  imm_o = $unsigned($signed(a_i) >>> shamt_i);
      default: imm_o = a_i;
    endcase
  end

  assign imm_done_o = 1'b1;
  assign step_val_o = 32'd0;
  assign val_o      = 32'd0;
  assign last_o     = 1'b0;
  assign unused_s   = ^{clk, rst_n, load_i, step_i};
`else
  logic [31:0] val_q, val_d;
  logic [4:0]  cnt_q, cnt_d;
  shift_kind_t kind_q, kind_d;

  // Amounts 0 and 1 finish on acceptance; larger ones do the first bit at load.
  assign imm_o      = (shamt_i == 5'd0) ? a_i : shift_one(a_i, kind_i);
  assign imm_done_o = (shamt_i <= 5'd1);
  assign step_val_o = shift_one(val_q, kind_q);
  assign val_o      = val_q;
  assign last_o     = (cnt_q == 5'd1);

  // Next-state for the shift register and remaining-bit counter.
  always_comb begin
    val_d  = val_q;
    cnt_d  = cnt_q;
    kind_d = kind_q;
    if (load_i) begin
      val_d  = shift_one(a_i, kind_i);
      cnt_d  = shamt_i - 5'd1;
      kind_d = kind_i;
    end else if (step_i) begin
      val_d = step_val_o;
      cnt_d = cnt_q - 5'd1;
    end else begin
      val_d = val_q;
    end
  end

  // Shift state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q  <= 32'd0;
      cnt_q  <= 5'd0;
      kind_q <= SH_SLL;
    end else begin
      val_q  <= val_d;
      cnt_q  <= cnt_d;
      kind_q <= kind_d;
    end
  end
`endif

endmodule

// File: rtl/alu_exec.sv
// ALU execution unit: IDLE/SHIFT/HOLD control, valid/ready handshake and result register.
module alu_exec
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  alu_exec_if.slave  bus
);

  state_t      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] result_q, result_d;
  logic        cond_q, cond_d;
  logic        illegal_q, illegal_d;

  logic        in_ready_s, accept_s;
  logic [31:0] dec_result_s;
  logic        dec_cond_s, dec_illegal_s, dec_is_shift_s;
  shift_kind_t dec_kind_s;
  logic        sh_load_s, sh_step_s, sh_imm_done_s, sh_last_s;
  logic [31:0] sh_imm_s, sh_step_val_s, sh_val_s;

  alu_decoder u_dec (
    .alu_ctrl_i   (bus.alu_ctrl),
    .neg_i        (bus.neg),
    .br_ctrl_i    (bus.br_ctrl),
    .src_a_i      (bus.src_a),
    .src_b_i      (bus.src_b),
    .result_o     (dec_result_s),
    .cond_o       (dec_cond_s),
    .illegal_o    (dec_illegal_s),
    .is_shift_o   (dec_is_shift_s),
    .shift_kind_o (dec_kind_s)
  );

  alu_shifter u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (sh_load_s),
    .step_i     (sh_step_s),
    .kind_i     (dec_kind_s),
    .a_i        (bus.src_a),
    .shamt_i    (bus.src_b[4:0]),
    .imm_o      (sh_imm_s),
    .imm_done_o (sh_imm_done_s),
    .step_val_o (sh_step_val_s),
    .val_o      (sh_val_s),
    .last_o     (sh_last_s)
  );

  // Gated by rst_n so no operation is offered acceptance during the reset cycle.
  assign in_ready_s = rst_n && (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cond      = cond_q;
  assign bus.illegal   = illegal_q;

  // Control FSM and output register next-state.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    result_d    = result_q;
    cond_d      = cond_q;
    illegal_d   = illegal_q;
    sh_load_s   = 1'b0;
    sh_step_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (dec_is_shift_s && !sh_imm_done_s) begin
            sh_load_s = 1'b1;
            state_d   = ST_SHIFT;
          end else begin
            out_valid_d = 1'b1;
            result_d    = dec_is_shift_s ? sh_imm_s : dec_result_s;
            cond_d      = dec_cond_s;
            illegal_d   = dec_illegal_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sh_step_s = 1'b1;
        if (sh_last_s) begin
          // A still-unconsumed result parks the finished value in the shifter.
          if (out_valid_q && !bus.out_ready) begin
            state_d = ST_HOLD;
          end else begin
            out_valid_d = 1'b1;
            result_d    = sh_step_val_s;
            cond_d      = 1'b0;
            illegal_d   = 1'b0;
            state_d     = ST_IDLE;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (!out_valid_q || bus.out_ready) begin
          out_valid_d = 1'b1;
          result_d    = sh_val_s;
          cond_d      = 1'b0;
          illegal_d   = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      cond_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      cond_q      <= cond_d;
      illegal_q   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed ops push expectations, a monitor checks results.
module tb_alu_exec;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_if bus();

  alu_exec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        cond;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;
  int stall_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a handshake completes on the next rising edge, so check it here.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got 0x%08h with no pending expectation", bus.result);
      end else begin
        e = sb_q.pop_front();
        check("result", bus.result, e.res);
        check("cond", {31'd0, bus.cond}, {31'd0, e.cond});
        check("illegal", {31'd0, bus.illegal}, {31'd0, e.ill});
      end
    end
  end

  task automatic issue(input logic [6:0] c, input logic n, input logic [1:0] br,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ec, input logic ei, input bit push);
    bit acc;
    acc = 1'b0;
    bus.alu_ctrl = c;
    bus.neg      = n;
    bus.br_ctrl  = br;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        if (push) sb_q.push_back({er, ec, ei});
      end else begin
        stall_cycles++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: op 0x%02h never accepted", c);
    end
  endtask

  task automatic measure(input string name, input int exp_lat);
    int lat;
    bit busy_ok;
    bit seen;
    lat = 0;
    busy_ok = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) seen = 1'b1;
      else if (bus.in_ready) busy_ok = 1'b0;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_busy"}, {31'd0, busy_ok}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit quiet;
    int s0;
    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = 7'd0;
    bus.neg       = 1'b0;
    bus.br_ctrl   = 2'd0;
    bus.src_a     = 32'd0;
    bus.src_b     = 32'd0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_ctl", {29'd0, bus.out_valid, bus.cond, bus.illegal}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    @(posedge clk);
    #1;

    issue(OP_ADD, 1'b0, BR_NONE, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1);
    measure("add", 1);

    // Back-to-back burst: no stalls expected under continuous out_ready.
    s0 = stall_cycles;
    issue(OP_SUB, 1'b0, BR_NONE, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);
    issue(OP_AND, 1'b0, BR_NONE, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b1);
    issue(OP_OR,  1'b0, BR_NONE, 32'h00FF0000, 32'h0000FF00, 32'h00FFFF00, 1'b0, 1'b0, 1'b1);
    issue(OP_LUI, 1'b0, BR_NONE, 32'h00001234, 32'hABCD0000, 32'hABCD0000, 1'b0, 1'b0, 1'b1);
    issue(OP_XOR, 1'b0, BR_NONE, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0, 1'b1);
    issue(OP_ADD, 1'b1, BR_EQ,   32'd5, 32'd5, 32'd10, 1'b0, 1'b0, 1'b1);
    issue(OP_SCOMP, 1'b0, BR_LT,   32'hFFFFFFFE, 32'd1, 32'd1, 1'b1, 1'b0, 1'b1);
    issue(OP_SCOMP, 1'b0, BR_LTU,  32'hFFFFFFFE, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1);
    issue(OP_SCOMP, 1'b1, BR_EQ,   32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1);
    issue(OP_SCOMP, 1'b1, BR_NONE, 32'd9, 32'd3, 32'd1, 1'b1, 1'b0, 1'b1);
    issue(OP_SCOMP, 1'b1, BR_LT,   32'd3, 32'd3, 32'd1, 1'b1, 1'b0, 1'b1);
    check("burst_stalls", stall_cycles - s0, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    issue(OP_SLL, 1'b0, BR_NONE, 32'h12345678, 32'd0, 32'h12345678, 1'b0, 1'b0, 1'b1);
    measure("sll0", 1);
    issue(OP_SLL, 1'b0, BR_NONE, 32'h80000001, 32'hFFFFFFE1, 32'h00000002, 1'b0, 1'b0, 1'b1);
    measure("sll1", 1);
    issue(OP_SRA, 1'b0, BR_NONE, 32'h40000000, 32'd2, 32'h10000000, 1'b0, 1'b0, 1'b1);
    measure("sra2", 2);
    issue(OP_SLL, 1'b0, BR_NONE, 32'h00000003, 32'd3, 32'h00000018, 1'b0, 1'b0, 1'b1);
    measure("sll3", 3);
    issue(OP_SRL, 1'b0, BR_NONE, 32'hF0000000, 32'd4, 32'h0F000000, 1'b0, 1'b0, 1'b1);
    measure("srl4", 4);
    issue(OP_SRA, 1'b0, BR_NONE, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    measure("sra31", 31);

    // Backpressure: XOR result must hold while the next op waits.
    bus.out_ready = 1'b0;
    issue(OP_XOR, 1'b0, BR_NONE, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b1);
    bus.alu_ctrl = OP_ADD;
    bus.neg      = 1'b0;
    bus.br_ctrl  = BR_NONE;
    bus.src_a    = 32'd1;
    bus.src_b    = 32'd2;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_result", bus.result, 32'h0F0F0F0F);
      check("hold_ctl", {28'd0, bus.out_valid, bus.in_ready, bus.cond, bus.illegal}, 32'h8);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("resume_in_ready", {31'd0, bus.in_ready}, 32'd1);
    sb_q.push_back({32'd3, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("no_bubble", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Reset in the middle of an iterative shift abandons it.
    issue(OP_SRL, 1'b0, BR_NONE, 32'hFFFF0000, 32'd10, 32'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    quiet = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.out_valid) quiet = 1'b0;
    end
    check("abort_no_result", {31'd0, quiet}, 32'd1);
    @(posedge clk);
    #1;

    issue(7'h7F, 1'b1, BR_EQ, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 1'b1);
    measure("illegal", 1);
    issue(7'h02, 1'b0, BR_NONE, 32'd4, 32'd4, 32'd0, 1'b0, 1'b1, 1'b1);
    issue(OP_ADD, 1'b0, BR_NONE, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
